decoder_3x8: RTL and testbench

DECODER_3X8 -- requirements
Module: decoder_3x8

---
 rtl/decoder_3x8.sv | 24 ++
 tb/tb_decoder_3x8.sv | 114 +++++++++++
 2 files changed

// File: rtl/decoder_3x8.sv
// decoder_3x8: registered 3-to-8 one-hot decoder, selectable output polarity; DECODER_3X8_VALID_EN adds a valid flag
module decoder_3x8 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] y,
  input  logic       enable,
  input  logic       s2,
  input  logic       s1,
  input  logic       s0
`ifdef DECODER_3X8_VALID_EN
  ,
  output logic       valid
`endif
);
  localparam logic [7:0] inact = OUT_ACTIVE_LOW ? 8'hff : 8'h00;
  logic [7:0] y_nxt;
  always_comb y_nxt = enable ? inact ^ (8'h01 << {s2, s1, s0}) : inact;
  always_ff @(posedge clk) y <= rst_n ? y_nxt : inact;
`ifdef DECODER_3X8_VALID_EN
  always_ff @(posedge clk) valid <= rst_n && enable;
`endif
endmodule

// File: tb/tb_decoder_3x8.sv
// tb_decoder_3x8: directed vectors feed a queue of expected outputs; a monitor pops and compares each cycle
module tb_decoder_3x8;
  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       v;
  } exp_t;
  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic [2:0] sel;
    logic [7:0] lo;
    logic [7:0] hi;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [7:0] y_lo, y_hi;
  logic valid_lo, valid_hi;
  exp_t q[$];
  exp_t last;
  int tests = 0;
  int fails = 0;
  vec_t vecs[18];
  always #5 clk = ~clk;
  decoder_3x8 u_lo (
    .clk(clk), .rst_n(rst_n), .y(y_lo), .enable(enable), .s2(sel[2]), .s1(sel[1]), .s0(sel[0])
`ifdef DECODER_3X8_VALID_EN
    , .valid(valid_lo)
`endif
  );
  decoder_3x8 #(.OUT_ACTIVE_LOW(1'b1)) u_hi (
    .clk(clk), .rst_n(rst_n), .y(y_hi), .enable(enable), .s2(sel[2]), .s1(sel[1]), .s0(sel[0])
`ifdef DECODER_3X8_VALID_EN
    , .valid(valid_hi)
`endif
  );
`ifndef DECODER_3X8_VALID_EN
  assign valid_lo = 1'b0;
  assign valid_hi = 1'b0;
`endif
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        last = e;
        check8("y_active_high", y_lo, e.lo);
        check8("y_active_low", y_hi, e.hi);
`ifdef DECODER_3X8_VALID_EN
        check8("valid_lo", {7'd0, valid_lo}, {7'd0, e.v});
        check8("valid_hi", {7'd0, valid_hi}, {7'd0, e.v});
`endif
      end
    end
  end
  initial begin
    vecs[0]  = '{1'b0, 1'b1, 3'd5, 8'h00, 8'hff};
    vecs[1]  = '{1'b0, 1'b1, 3'd5, 8'h00, 8'hff};
    vecs[2]  = '{1'b1, 1'b1, 3'd0, 8'h01, 8'hfe};
    vecs[3]  = '{1'b1, 1'b1, 3'd1, 8'h02, 8'hfd};
    vecs[4]  = '{1'b1, 1'b1, 3'd2, 8'h04, 8'hfb};
    vecs[5]  = '{1'b1, 1'b1, 3'd3, 8'h08, 8'hf7};
    vecs[6]  = '{1'b1, 1'b1, 3'd4, 8'h10, 8'hef};
    vecs[7]  = '{1'b1, 1'b1, 3'd5, 8'h20, 8'hdf};
    vecs[8]  = '{1'b1, 1'b1, 3'd6, 8'h40, 8'hbf};
    vecs[9]  = '{1'b1, 1'b1, 3'd7, 8'h80, 8'h7f};
    vecs[10] = '{1'b1, 1'b0, 3'd3, 8'h00, 8'hff};
    vecs[11] = '{1'b1, 1'b1, 3'd2, 8'h04, 8'hfb};
    vecs[12] = '{1'b1, 1'b0, 3'd2, 8'h00, 8'hff};
    vecs[13] = '{1'b1, 1'b1, 3'd6, 8'h40, 8'hbf};
    vecs[14] = '{1'b0, 1'b1, 3'd6, 8'h00, 8'hff};
    vecs[15] = '{1'b1, 1'b1, 3'd6, 8'h40, 8'hbf};
    vecs[16] = '{1'b1, 1'b1, 3'd7, 8'h80, 8'h7f};
    vecs[17] = '{1'b1, 1'b1, 3'd1, 8'h02, 8'hfd};
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      enable = vecs[i].en;
      if (i == 16) begin
        sel = 3'd1;
        #1;
        check8("glitch_lo_a", y_lo, 8'h40);
        sel = 3'd7;
        #1;
        sel = 3'd1;
        #1;
        check8("glitch_lo_b", y_lo, 8'h40);
        check8("glitch_hi", y_hi, 8'hbf);
      end
      sel = vecs[i].sel;
      q.push_back('{vecs[i].lo, vecs[i].hi, vecs[i].rst_n && vecs[i].en});
    end
    for (int n = 0; n < 20 && q.size() > 0; n++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected outputs never checked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
